// File: rtl/vrf_wb_tracker.sv
// Write-back tracker for the vector address/offset stream: 2-entry beat FIFO
// in front of the VRF write port, group-completion reporting and order checking.
module vrf_wb_tracker #(
    parameter int VLEN       = 16384,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = $clog2(VLEN / DATA_WIDTH),
    parameter int CNT_WIDTH  = ADDR_WIDTH + OFF_WIDTH + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_start,
    input  logic                          in_end,
    input  logic                          in_widen,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic [OFF_WIDTH-1:0]          in_off,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          wr_en,
    input  logic                          wr_ready,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [OFF_WIDTH-1:0]          wr_off,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          done,
    output logic [ADDR_WIDTH+OFF_WIDTH-1:0] done_addr,
    output logic [CNT_WIDTH-1:0]          done_beats,
    output logic [1:0]                    err,
    input  logic                          err_clr,
    output logic                          busy
);

    localparam int POS_WIDTH = ADDR_WIDTH + OFF_WIDTH;

    typedef enum logic [0:0] {
        T_IDLE  = 1'b0,
        T_GROUP = 1'b1
    } trk_state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_WIDTH'(1);
        end
    endfunction

    logic [POS_WIDTH-1:0]  fifo_pos_r  [2];
    logic [DATA_WIDTH-1:0] fifo_data_r [2];
    logic [1:0]            fifo_start_r;
    logic [1:0]            fifo_end_r;
    logic                  rd_ptr_r;
    logic                  wr_ptr_r;
    logic [1:0]            count_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic [POS_WIDTH-1:0]  in_pos_s;
    logic [POS_WIDTH-1:0]  head_pos_s;
    logic                  head_start_s;
    logic                  head_end_s;

    trk_state_t            state_r;
    logic [POS_WIDTH-1:0]  last_r;
    logic                  widen_r;
    logic                  phase_r;
    logic [POS_WIDTH-1:0]  exp_pos_s;
    logic                  frame_err_s;
    logic                  seq_err_s;

    logic [POS_WIDTH-1:0]  base_r;
    logic [CNT_WIDTH-1:0]  wcount_r;
    logic [POS_WIDTH-1:0]  base_next_s;
    logic [CNT_WIDTH-1:0]  cnt_next_s;
    logic                  done_r;
    logic [POS_WIDTH-1:0]  done_addr_r;
    logic [CNT_WIDTH-1:0]  done_beats_r;
    logic [1:0]            err_r;

    // FIFO status, handshakes and head-entry decode.
    always_comb begin
        empty_s      = (count_r == 2'd0);
        full_s       = (count_r == 2'd2);
        push_s       = in_valid & ~full_s;
        pop_s        = ~empty_s & wr_ready;
        in_pos_s     = {in_addr, in_off};
        head_pos_s   = fifo_pos_r[rd_ptr_r];
        head_start_s = fifo_start_r[rd_ptr_r];
        head_end_s   = fifo_end_r[rd_ptr_r];
    end

    // FIFO payload storage; contents are only meaningful while counted valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_pos_r[wr_ptr_r]  <= in_pos_s;
            fifo_data_r[wr_ptr_r] <= in_data;
        end else begin
            fifo_pos_r[wr_ptr_r]  <= fifo_pos_r[wr_ptr_r];
            fifo_data_r[wr_ptr_r] <= fifo_data_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and beat markers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r     <= 1'b0;
            wr_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
            fifo_start_r <= 2'b00;
            fifo_end_r   <= 2'b00;
        end else begin
            if (push_s) begin
                fifo_start_r[wr_ptr_r] <= in_start;
                fifo_end_r[wr_ptr_r]   <= in_end;
                wr_ptr_r               <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Expected input position and error detection for the accepted beat.
    always_comb begin
        exp_pos_s   = last_r + {{(POS_WIDTH-1){1'b0}}, ~(widen_r & ~phase_r)};
        frame_err_s = 1'b0;
        seq_err_s   = 1'b0;
        if (push_s) begin
            if (in_start) begin
                frame_err_s = (state_r == T_GROUP);
            end else if (state_r == T_IDLE) begin
                frame_err_s = 1'b1;
            end else begin
                seq_err_s = (in_pos_s != exp_pos_s);
            end
        end else begin
            frame_err_s = 1'b0;
        end
    end

    // Input-side group tracker; a start beat always restarts tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= T_IDLE;
            last_r  <= {POS_WIDTH{1'b0}};
            widen_r <= 1'b0;
            phase_r <= 1'b0;
        end else if (push_s) begin
            if (in_start) begin
                last_r  <= in_pos_s;
                widen_r <= in_widen;
                phase_r <= 1'b0;
                state_r <= in_end ? T_IDLE : T_GROUP;
            end else if (state_r == T_GROUP) begin
                last_r  <= in_pos_s;
                phase_r <= ~phase_r;
                state_r <= in_end ? T_IDLE : T_GROUP;
            end else begin
                state_r <= T_IDLE;
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Write-side base/count as they will stand after the current pop.
    always_comb begin
        if (head_start_s) begin
            base_next_s = head_pos_s;
            cnt_next_s  = CNT_WIDTH'(1);
        end else begin
            base_next_s = base_r;
            cnt_next_s  = sat_inc(wcount_r);
        end
    end

    // Write-side group counter and completion report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r       <= {POS_WIDTH{1'b0}};
            wcount_r     <= {CNT_WIDTH{1'b0}};
            done_r       <= 1'b0;
            done_addr_r  <= {POS_WIDTH{1'b0}};
            done_beats_r <= {CNT_WIDTH{1'b0}};
        end else if (pop_s) begin
            base_r   <= base_next_s;
            wcount_r <= cnt_next_s;
            done_r   <= head_end_s;
            if (head_end_s) begin
                done_addr_r  <= base_next_s;
                done_beats_r <= cnt_next_s;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 2'b00;
        end else begin
            err_r <= (err_clr ? 2'b00 : err_r) | {seq_err_s, frame_err_s};
        end
    end

    assign in_ready   = ~full_s;
    assign wr_en      = ~empty_s;
    assign wr_addr    = head_pos_s[POS_WIDTH-1:OFF_WIDTH];
    assign wr_off     = head_pos_s[OFF_WIDTH-1:0];
    assign wr_data    = fifo_data_r[rd_ptr_r];
    assign done       = done_r;
    assign done_addr  = done_addr_r;
    assign done_beats = done_beats_r;
    assign err        = err_r;
    assign busy       = (state_r == T_GROUP) | ~empty_s;

endmodule

// File: tb/tb_vrf_wb_tracker.sv
// Bench for vrf_wb_tracker: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference of the write-back behaviour.
module tb_vrf_wb_tracker;

    localparam int AW = 5;
    localparam int OW = 8;
    localparam int DW = 64;
    localparam int CW = 14;
    localparam int PW = AW + OW;

    typedef struct {
        logic [PW-1:0] pos;
        logic [DW-1:0] data;
        logic          s;
        logic          e;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_start, in_end, in_widen;
    logic [AW-1:0] in_addr;
    logic [OW-1:0] in_off;
    logic [DW-1:0] in_data;
    logic          wr_en, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [OW-1:0] wr_off;
    logic [DW-1:0] wr_data;
    logic          done;
    logic [PW-1:0] done_addr;
    logic [CW-1:0] done_beats;
    logic [1:0]    err;
    logic          err_clr;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // reference state
    beat_t         m_q[$];
    logic          m_open;
    logic [PW-1:0] m_last;
    logic          m_widen;
    int            m_n;
    logic [PW-1:0] m_base;
    int            m_cnt;
    logic          m_done;
    logic [PW-1:0] m_done_addr;
    int            m_done_beats;
    logic [1:0]    m_err;

    // random generator state
    int            g_left;
    logic          g_widen;
    logic [PW-1:0] g_pos;
    int            g_n;
    logic [PW-1:0] cur_pos;
    logic          cur_s, cur_e, cur_w;

    vrf_wb_tracker dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_start(in_start), .in_end(in_end),
        .in_widen(in_widen), .in_addr(in_addr), .in_off(in_off), .in_data(in_data),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_off(wr_off), .wr_data(wr_data),
        .done(done), .done_addr(done_addr), .done_beats(done_beats),
        .err(err), .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_open = 1'b0; m_last = '0; m_widen = 1'b0; m_n = 0;
        m_base = '0; m_cnt = 0;
        m_done = 1'b0; m_done_addr = '0; m_done_beats = 0;
        m_err = 2'b00;
    endtask

    // Check all outputs, advance the reference by one clock, then move to the next negedge.
    task automatic cyc();
        logic          push, pop;
        logic [1:0]    new_err;
        logic [PW-1:0] p, exp_p;
        beat_t         b;
        chk("in_ready", in_ready, m_q.size() < 2);
        chk("wr_en", wr_en, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("wr_pos", {wr_addr, wr_off}, m_q[0].pos);
            chk("wr_data", wr_data, m_q[0].data);
        end
        chk("done", done, m_done);
        chk("done_addr", done_addr, m_done_addr);
        chk("done_beats", done_beats, m_done_beats);
        chk("err", err, m_err);
        chk("busy", busy, m_open || (m_q.size() != 0));

        push = in_valid && (m_q.size() < 2);
        pop  = (m_q.size() != 0) && wr_ready;
        new_err = 2'b00;
        m_done = 1'b0;
        if (pop) begin
            b = m_q.pop_front();
            if (b.s) begin
                m_base = b.pos; m_cnt = 1;
            end else if (m_cnt < (1 << CW) - 1) begin
                m_cnt++;
            end
            if (b.e) begin
                m_done = 1'b1; m_done_addr = m_base; m_done_beats = m_cnt;
            end
        end
        if (push) begin
            p = {in_addr, in_off};
            if (in_start) begin
                if (m_open) new_err[0] = 1'b1;
                m_open = !in_end; m_last = p; m_widen = in_widen; m_n = 1;
            end else if (!m_open) begin
                new_err[0] = 1'b1;
            end else begin
                // widened groups repeat every position twice
                exp_p = m_last + ((m_widen && (m_n % 2 == 1)) ? PW'(0) : PW'(1));
                if (p != exp_p) new_err[1] = 1'b1;
                m_last = p; m_n++;
                if (in_end) m_open = 1'b0;
            end
            b.pos = p; b.data = in_data; b.s = in_start; b.e = in_end;
            m_q.push_back(b);
        end
        m_err = (err_clr ? 2'b00 : m_err) | new_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [OW-1:0] o,
                         input logic s, input logic e, input logic w);
        in_valid = 1'b1; in_addr = a; in_off = o; in_start = s; in_end = e; in_widen = w;
        in_data = {$urandom, $urandom};
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [OW-1:0] o,
                        input logic s, input logic e, input logic w);
        logic acc;
        drive(a, o, s, e, w);
        for (int i = 0; i < 20; i++) begin
            acc = (m_q.size() < 2);
            cyc();
            if (acc) break;
            if (i == 19) begin
                failures++;
                $display("FAIL beat_timeout observed=not accepted expected=accepted");
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic gen_next();
        if (g_left == 0) begin
            g_left  = $urandom_range(1, 6);
            g_widen = 1'($urandom_range(0, 1));
            g_pos   = PW'($urandom);
            g_n     = 0;
            cur_s   = ($urandom_range(0, 19) != 0);
            cur_w   = g_widen;
        end else begin
            cur_s = ($urandom_range(0, 29) == 0);
            cur_w = 1'($urandom_range(0, 1));
            if (!(g_widen && (g_n % 2 == 1))) g_pos = g_pos + PW'(1);
        end
        cur_pos = ($urandom_range(0, 19) == 0) ? PW'($urandom) : g_pos;
        cur_e = (g_left == 1);
        g_left--;
        g_n++;
    endtask

    initial begin
        logic acc;
        int   k;
        rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; in_widen = 1'b0;
        in_addr = '0; in_off = '0; in_data = '0; wr_ready = 1'b1; err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        idle(1);

        // single start+end beat
        beat(5'd3, 8'h05, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("single_done_addr", done_addr, {5'd3, 8'h05});
        chk("single_done_beats", done_beats, 14'd1);
        chk("single_err", err, 2'b00);

        // non-widen group carrying into the register index
        beat(5'd2, 8'hFE, 1'b1, 1'b0, 1'b0);
        beat(5'd2, 8'hFF, 1'b0, 1'b0, 1'b0);
        beat(5'd3, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("carry_done_addr", done_addr, {5'd2, 8'hFE});
        chk("carry_done_beats", done_beats, 14'd3);
        chk("carry_err", err, 2'b00);

        // widened group, then one with a bad repeat
        beat(5'd4, 8'd0, 1'b1, 1'b0, 1'b1);
        beat(5'd4, 8'd0, 1'b0, 1'b0, 1'b0);
        beat(5'd4, 8'd1, 1'b0, 1'b0, 1'b0);
        beat(5'd4, 8'd1, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("widen_done_beats", done_beats, 14'd4);
        chk("widen_err", err, 2'b00);
        beat(5'd4, 8'd0, 1'b1, 1'b0, 1'b1);
        beat(5'd4, 8'd0, 1'b0, 1'b0, 1'b0);
        beat(5'd4, 8'd0, 1'b0, 1'b0, 1'b0);
        beat(5'd4, 8'd1, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("widen_bad_err", err, 2'b10);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        chk("clr_seq_err", err, 2'b00);

        // back-pressure: only two beats fit while the VRF stalls
        wr_ready = 1'b0; k = 0;
        for (int c = 0; c < 40 && k < 6; c++) begin
            if (c == 5) begin
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_wr_en", wr_en, 1'b1);
                wr_ready = 1'b1;
            end
            drive(5'd9, 8'(10 + k), k == 0, k == 5, 1'b0);
            acc = (m_q.size() < 2);
            cyc();
            if (acc) k++;
        end
        idle(4);
        chk("stall_done_beats", done_beats, 14'd6);
        chk("stall_done_addr", done_addr, {5'd9, 8'd10});

        // framing error while idle, clear, and clear racing a new error
        beat(5'd7, 8'h33, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("frame_err", err, 2'b01);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        chk("clr_frame_err", err, 2'b00);
        err_clr = 1'b1;
        beat(5'd7, 8'h34, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        idle(2);
        chk("clr_vs_new_err", err, 2'b01);

        // asynchronous reset with two beats queued mid-group
        wr_ready = 1'b0;
        beat(5'd1, 8'd0, 1'b1, 1'b0, 1'b0);
        beat(5'd1, 8'd1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_done_beats", done_beats, 14'd0);
        chk("rst_err", err, 2'b00);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wr_ready = 1'b1;
        idle(4);

        // random traffic
        g_left = 0; g_n = 0; g_pos = '0; g_widen = 1'b0;
        gen_next();
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            err_clr  = ($urandom_range(0, 49) == 0);
            in_addr  = cur_pos[PW-1:OW]; in_off = cur_pos[OW-1:0];
            in_start = cur_s; in_end = cur_e; in_widen = cur_w;
            in_data  = {$urandom, $urandom};
            acc = in_valid && (m_q.size() < 2);
            cyc();
            if (acc) gen_next();
        end
        err_clr = 1'b0; wr_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
